// File: rtl/dehaze_pkg.sv
// dehaze_pkg: shared pixel width, default image geometry and window-generator FSM states.
package dehaze_pkg;
   localparam int PIXEL_W = 24;
   localparam int DEF_IMG_WIDTH = 640;
   localparam int DEF_IMG_HEIGHT = 480;
   typedef enum logic [1:0] {FILL, RUN, FLUSH} win_state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image line of pixels, addressed by column; read returns the old word
// while the enabled edge overwrites it (read-before-write).
module line_buffer import dehaze_pkg::*; #(
   parameter int DEPTH = DEF_IMG_WIDTH,
   parameter int WIDTH = PIXEL_W
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   assign rdata = mem[addr];
   always_ff @(posedge clk) if (en) mem[addr] <= wdata;
endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster 3x3 window generator with two chained line buffers.
// Border taps are zero unless WIN_BORDER_REPLICATE_EN is defined (edge replicate).
module window_gen_3x3 import dehaze_pkg::*; #(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIXEL_W-1:0] pixel_in,
   input  logic               pixel_valid,
   output logic               in_ready,
   output logic [PIXEL_W-1:0] in1, in2, in3, in4, in5, in6, in7, in8, in9,
   output logic               window_valid,
   output logic               frame_done
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT + 2);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_END  = RW'(IMG_HEIGHT);
   localparam logic [RW-1:0] ROW_OVER = RW'(IMG_HEIGHT + 1);
   win_state_t state, state_nx;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic rdy, last_win, acc, adv, emit, col0, flush_end;
   logic top_bad, bot_bad, lft_bad, rgt_bad;
   logic [PIXEL_W-1:0] lb0_q, lb1_q;
   logic [PIXEL_W-1:0] nc [3];
   logic [PIXEL_W-1:0] sc [2][3];
   logic [PIXEL_W-1:0] g [3][3];
   logic [PIXEL_W-1:0] w [3][3];
   logic [PIXEL_W-1:0] win [3][3];
   assign in_ready  = rdy && state != FLUSH;
   assign acc       = pixel_valid && in_ready;
   assign adv       = acc || state == FLUSH;
   assign emit      = (state == RUN && acc) || state == FLUSH;
   assign col0      = col == '0;
   assign flush_end = state == FLUSH && col0 && row == ROW_OVER;
   // (row,col) is the raster slot being consumed; col 0 closes the previous line's last window
   assign top_bad = col0 ? row == RW'(2) : row == RW'(1);
   assign bot_bad = col0 ? row == ROW_OVER : row == ROW_END;
   assign lft_bad = col == CW'(1);
   assign rgt_bad = col0;
   always_comb begin
      state_nx = (state == FILL && acc && row == RW'(1) && col0) ? RUN :
                 (state == RUN && acc && row == LAST_ROW && col == LAST_COL) ? FLUSH :
                 flush_end ? FILL : state;
   end
   line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb0 (
      .clk(clk), .en(adv), .addr(col), .wdata(pixel_in), .rdata(lb0_q));
   line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb1 (
      .clk(clk), .en(adv), .addr(col), .wdata(lb0_q), .rdata(lb1_q));
   assign nc = '{lb1_q, lb0_q, pixel_in};
   for (genvar i = 0; i < 3; i++) begin : g_row
      assign g[i][0] = sc[0][i];
      assign g[i][1] = sc[1][i];
      assign g[i][2] = nc[i];
      for (genvar j = 0; j < 3; j++) begin : g_col
         logic rb, cb;
         assign rb = (i == 0 && top_bad) || (i == 2 && bot_bad);
         assign cb = (j == 0 && lft_bad) || (j == 2 && rgt_bad);
`ifdef WIN_BORDER_REPLICATE_EN
         assign w[i][j] = rb ? (cb ? g[1][1] : g[1][j]) : (cb ? g[i][1] : g[i][j]);
`else
         assign w[i][j] = (rb || cb) ? '0 : g[i][j];
`endif
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= FILL;
         row          <= '0;
         col          <= '0;
         rdy          <= 1'b0;
         last_win     <= 1'b0;
         window_valid <= 1'b0;
         frame_done   <= 1'b0;
         sc           <= '{default: '0};
         win          <= '{default: '0};
      end else begin
         state        <= state_nx;
         rdy          <= 1'b1;
         last_win     <= flush_end;
         frame_done   <= last_win;
         window_valid <= emit;
         if (adv) begin
            sc[0] <= sc[1];
            sc[1] <= nc;
            col   <= (flush_end || col == LAST_COL) ? '0 : col + 1'b1;
            row   <= flush_end ? '0 : (col == LAST_COL) ? row + 1'b1 : row;
         end
         if (emit) win <= w;
      end
   end
   assign in1 = win[0][0];
   assign in2 = win[0][1];
   assign in3 = win[0][2];
   assign in4 = win[1][0];
   assign in5 = win[1][1];
   assign in6 = win[1][2];
   assign in7 = win[2][0];
   assign in8 = win[2][1];
   assign in9 = win[2][2];
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed frames on a 4x3 image; border expectations follow WIN_BORDER_REPLICATE_EN.
module tb_window_gen_3x3;
   localparam int W = 4, H = 3, NPX = W * H;
   logic clk = 1'b0, rst = 1'b0, pixel_valid = 1'b0;
   logic [23:0] pixel_in = '0;
   logic in_ready, window_valid, frame_done;
   logic [23:0] in1, in2, in3, in4, in5, in6, in7, in8, in9;
   logic [215:0] win_flat;
   int errs = 0, checks = 0;
   int cyc = 0, first_acc = 0, acc_n = 0, win_n = 0, fd_n = 0, low_run = 0;
   logic prev_adv = 1'b0, wv_prev = 1'b0;
   int bases [$];
`ifdef WIN_BORDER_REPLICATE_EN
   int e00 [9] = '{1, 1, 2, 1, 1, 2, 5, 5, 6};
   int e23 [9] = '{7, 8, 8, 11, 12, 12, 11, 12, 12};
`else
   int e00 [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
   int e23 [9] = '{7, 8, 0, 11, 12, 0, 0, 0, 0};
`endif
   always #5 clk = ~clk;
   window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5), .in6(in6), .in7(in7), .in8(in8), .in9(in9),
      .window_valid(window_valid), .frame_done(frame_done));
   assign win_flat = {in1, in2, in3, in4, in5, in6, in7, in8, in9};
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic int tap(input int k);
      return int'(win_flat[(8 - k) * 24 +: 24]);
   endfunction
   function automatic int px(input int base, input int r, input int c);
`ifdef WIN_BORDER_REPLICATE_EN
      r = r < 0 ? 0 : (r >= H ? H - 1 : r);
      c = c < 0 ? 0 : (c >= W ? W - 1 : c);
`else
      if (r < 0 || r >= H || c < 0 || c >= W) return 0;
`endif
      return base + r * W + c;
   endfunction
   task automatic check_window(input int b, input int idx);
      int r = idx / W, c = idx % W;
      for (int k = 0; k < 9; k++)
         chk($sformatf("f%0d_w%0d_in%0d", b, idx, k + 1), tap(k), px(b, r + k / 3 - 1, c + k % 3 - 1));
      if (b == 1 && idx == 0) begin
         for (int k = 0; k < 9; k++) chk($sformatf("w00_in%0d", k + 1), tap(k), e00[k]);
         chk("first_window_latency", cyc - first_acc, 5);
      end
      if (b == 1 && idx == NPX - 1)
         for (int k = 0; k < 9; k++) chk($sformatf("w23_in%0d", k + 1), tap(k), e23[k]);
   endtask
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      prev_adv <= !in_ready || pixel_valid;
      if (!rst) acc_n <= 0;
      else if (pixel_valid && in_ready) begin
         if (acc_n % NPX == 0) first_acc <= cyc + 1;
         acc_n <= acc_n + 1;
      end
   end
   always @(negedge clk) begin
      wv_prev <= window_valid;
      if (!rst) begin
         win_n   <= 0;
         low_run <= 0;
      end else begin
         if (window_valid) begin
            chk("wv_only_after_accept", int'(prev_adv), 1);
            if (bases.size() == 0) chk("unexpected_window", 1, 0);
            else begin
               check_window(bases[0], win_n % NPX);
               if (win_n % NPX == NPX - 1) void'(bases.pop_front());
            end
            win_n <= win_n + 1;
         end
         if (frame_done) begin
            chk("fd_after_last_wv", int'(wv_prev), 1);
            chk("fd_whole_frame", win_n % NPX, 0);
            chk("fd_has_windows", int'(win_n > 0), 1);
            chk("fd_in_ready", int'(in_ready), 1);
            fd_n <= fd_n + 1;
         end
         if (!in_ready) low_run <= low_run + 1;
         else if (low_run != 0) begin
            chk("flush_len", low_run, W + 1);
            low_run <= 0;
         end
      end
   end
   task automatic check_reset_outputs();
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_window_valid", int'(window_valid), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      for (int k = 0; k < 9; k++) chk($sformatf("rst_in%0d", k + 1), tap(k), 0);
   endtask
   task automatic release_rst();
      @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rdy_after_release", int'(in_ready), 1);
   endtask
   task automatic send_px(input logic [23:0] v, input bit gap);
      int t = 0;
      pixel_valid = 1'b1;
      pixel_in = v;
      while (!in_ready && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (gap) begin
         pixel_valid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send_frame(input int base, input int n, input bit gap);
      bases.push_back(base);
      for (int i = 0; i < n; i++) send_px(24'(base + i), gap);
      pixel_valid = 1'b0;
   endtask
   task automatic flush_with_junk();
      int t = 0;
      pixel_valid = 1'b1;
      pixel_in = 24'hBADBAD;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (!in_ready && t < 40);
      pixel_valid = 1'b0;
      chk("junk_flush_ends", int'(in_ready), 1);
   endtask
   task automatic wait_fd(input int target);
      int t = 0;
      while (fd_n < target && t < 60) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("frame_done_seen", fd_n, target);
   endtask
   initial begin
      int w0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      release_rst();
      send_frame(1, NPX, 1'b0);
      flush_with_junk();
      wait_fd(1);
      chk("frame1_windows", win_n, NPX);
      send_frame(21, NPX, 1'b1);
      wait_fd(2);
      chk("gapped_windows", win_n, 2 * NPX);
      w0 = win_n;
      send_frame(41, NPX, 1'b0);
      send_frame(61, NPX, 1'b0);
      wait_fd(4);
      chk("b2b_windows", win_n - w0, 2 * NPX);
      send_frame(81, 7, 1'b0);
      rst = 1'b0;
      bases.delete();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      release_rst();
      repeat (4) @(posedge clk);
      #1;
      chk("no_stale_windows", win_n, 0);
      send_frame(101, NPX, 1'b0);
      wait_fd(5);
      chk("after_abort_windows", win_n, NPX);
      repeat (3) @(posedge clk);
      #1;
      chk("idle_window_valid", int'(window_valid), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
